seq_divider: RTL and testbench

//  Iterative signed integer divider for the ALU; the inverse operation of the combinational multiplier.

---
 rtl/alu_pkg.sv | 19 +
 rtl/seq_divider_if.sv | 30 +++
 rtl/div_step.sv | 22 ++
 rtl/seq_divider.sv | 136 +++++++++++++
 tb/tb_seq_divider.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: status vector bit positions and the divider state encoding.
package alu_pkg;

    // Bit positions inside the 4-bit ALU status vector {OVERFLOW,ZERO,NEG,CARRY}.
    localparam int ST_CARRY    = 0;
    localparam int ST_NEG      = 1;
    localparam int ST_ZERO     = 2;
    localparam int ST_OVERFLOW = 3;

    // Sequential divider control states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle of the sequential divider.
//
// Handshake: the requester raises start with operand1/operand2 stable for one
// clock. It is accepted only while the divider is idle (busy low); a start seen
// while busy is dropped, not queued. busy stays high from the cycle after the
// accepted start through the done cycle. done is a one-cycle pulse, and result,
// remainder and statusOut are valid from that cycle and hold until the next
// operation completes.
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic [3:0]       statusOut;

    modport master (
        output start, operand1, operand2,
        input  busy, done, result, remainder, statusOut
    );

    modport slave (
        input  start, operand1, operand2,
        output busy, done, result, remainder, statusOut
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left by one, then subtract the
// divisor magnitude from the partial remainder when it fits.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] rem_sh;
    logic           fits;

    // Shift-compare-subtract; rem_sh keeps the shifted-out bit so the compare is exact.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        fits     = (rem_sh >= {1'b0, divisor});
        rem_next = fits ? (rem_sh[WIDTH-1:0] - divisor) : rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: one quotient bit per cycle over WIDTH cycles,
// magnitudes divided unsigned and signs restored at the end. Fixed latency
// of WIDTH+3 cycles from accepted start to done, special cases included.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_divider_if.slave bus,
    output div_state_e dbg_state
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] op1_q, op2_q;
    logic [WIDTH-1:0] divisor_q, rem_q, quo_q;
    logic             q_neg_q, r_neg_q, div0_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] fix_result, fix_rem;
    logic [3:0]       fix_status;

    logic [WIDTH-1:0] result_q, remainder_q;
    logic [3:0]       status_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DIV exits on the step where the counter reads 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = PREP;
            PREP:    state_d = DIV;
            DIV:     if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, magnitude/sign preparation and the iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q     <= '0;
            op2_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op1_q <= bus.operand1;
                        op2_q <= bus.operand2;
                    end
                end
                PREP: begin
                    // |MIN| is 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
                    quo_q     <= op1_q[WIDTH-1] ? -op1_q : op1_q;
                    divisor_q <= op2_q[WIDTH-1] ? -op2_q : op2_q;
                    rem_q     <= '0;
                    q_neg_q   <= op1_q[WIDTH-1] ^ op2_q[WIDTH-1];
                    r_neg_q   <= op1_q[WIDTH-1];
                    div0_q    <= (op2_q == '0);
                    ovf_q     <= (op1_q == MIN_VAL) && (op2_q == '1);
                    cnt_q     <= CNT_W'(WIDTH);
                end
                DIV: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Sign correction, special-case override and status flags for the final result.
    always_comb begin
        fix_result = q_neg_q ? -quo_q : quo_q;
        fix_rem    = r_neg_q ? -rem_q : rem_q;
        if (div0_q) begin
            fix_result = '0;
            fix_rem    = op1_q;
        end else if (ovf_q) begin
            fix_result = MIN_VAL;
            fix_rem    = '0;
        end
        fix_status              = '0;
        fix_status[ST_CARRY]    = 1'b0;
        fix_status[ST_NEG]      = fix_result[WIDTH-1];
        fix_status[ST_ZERO]     = (fix_result == '0);
        fix_status[ST_OVERFLOW] = div0_q | ovf_q;
    end

    // Output registers: loaded only in FIX, held otherwise (including IDLE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            remainder_q <= '0;
            status_q    <= '0;
        end else if (state_q == FIX) begin
            result_q    <= fix_result;
            remainder_q <= fix_rem;
            status_q    <= fix_status;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.remainder = remainder_q;
    assign bus.statusOut = status_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: an 8-bit instance for directed cases and a
// 16-bit instance for random signed pairs, checked against a reference model.
module tb_seq_divider;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    seq_divider_if #(.WIDTH(8))  bus8();
    seq_divider_if #(.WIDTH(16)) bus16();
    div_state_e state8, state16;

    seq_divider #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus8),
        .dbg_state (state8)
    );

    seq_divider #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus16),
        .dbg_state (state16)
    );

    int n_vec = 0;
    int n_err = 0;
    // Scoreboard entries: {status[3:0], remainder[15:0], quotient[15:0]}.
    logic [35:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // Reference model: language-level signed division truncates toward zero
    // and % takes the sign of the dividend.
    function automatic logic [35:0] model(input int w, input int a, input int b);
        int q, r, minv;
        logic [15:0] mask, qb, rb;
        logic [3:0] st;
        minv = -(1 << (w - 1));
        mask = 16'((1 << w) - 1);
        st = 4'b0000;
        if (b == 0) begin
            q = 0; r = a; st[3] = 1'b1;
        end else if (a == minv && b == -1) begin
            q = minv; r = 0; st[3] = 1'b1;
        end else begin
            q = a / b; r = a % b;
        end
        qb = 16'(q) & mask;
        rb = 16'(r) & mask;
        st[1] = qb[w-1];
        st[2] = (qb == 16'd0);
        return {st, rb, qb};
    endfunction

    // ---------------- driver tasks ----------------
    // Issues one 8-bit division and waits for done. cyc is the cycle number
    // where done was seen (the start edge is edge 0), or -1 on timeout.
    // ign1/ign2 name cycles in which a stray start is raised while busy.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input int ign1, input int ign2,
                           output int cyc, output logic busy1);
        bit seen;
        exp_q.push_back(model(8, int'($signed(a)), int'($signed(b))));
        @(negedge clk);
        bus8.start = 1'b1; bus8.operand1 = a; bus8.operand2 = b;
        @(posedge clk);
        cyc = 1; seen = 0;
        @(negedge clk);
        bus8.start = 1'b0;
        busy1 = bus8.busy;
        while (!seen && cyc < 40) begin
            if (bus8.done === 1'b1) begin
                seen = 1;
            end else begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                bus8.start = (cyc == ign1 || cyc == ign2);
                if (bus8.start) begin
                    bus8.operand1 = 8'h7F; bus8.operand2 = 8'h01;
                end
            end
        end
        bus8.start = 1'b0;
        if (!seen) cyc = -1;
    endtask

    task automatic run_op16(input logic [15:0] a, input logic [15:0] b, output int cyc);
        bit seen;
        exp_q.push_back(model(16, int'($signed(a)), int'($signed(b))));
        @(negedge clk);
        bus16.start = 1'b1; bus16.operand1 = a; bus16.operand2 = b;
        @(posedge clk);
        cyc = 1; seen = 0;
        @(negedge clk);
        bus16.start = 1'b0;
        while (!seen && cyc < 60) begin
            if (bus16.done === 1'b1) begin
                seen = 1;
            end else begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
        end
        if (!seen) cyc = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus8.busy, bus8.done, bus8.result, bus8.remainder, bus8.statusOut} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs8: got busy=%b done=%b res=%h rem=%h st=%b want all zero",
                     bus8.busy, bus8.done, bus8.result, bus8.remainder, bus8.statusOut);
        end
        n_vec++;
        if ({bus16.busy, bus16.done, bus16.result, bus16.remainder, bus16.statusOut} !== 38'd0) begin
            n_err++;
            $display("FAIL reset_outputs16: got busy=%b done=%b res=%h rem=%h st=%b want all zero",
                     bus16.busy, bus16.done, bus16.result, bus16.remainder, bus16.statusOut);
        end
        n_vec++;
        if (state8 !== IDLE || state16 !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d/%0d want IDLE", state8, state16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed8();
        logic [7:0] ta[10] = '{8'd100, 8'h9C, 8'd5, 8'h80, 8'd7, 8'hF9, 8'hF9, 8'h7F, 8'd0, 8'd3};
        logic [7:0] tb[10] = '{8'd7,   8'd7,  8'd0, 8'hFF, 8'hFE, 8'd2, 8'hFE, 8'd1, 8'd5, 8'd9};
        logic [35:0] exp;
        logic busy1;
        int cyc;
        for (int i = 0; i < 10; i++) begin
            run_op8(ta[i], tb[i], -1, -1, cyc, busy1);
            exp = exp_q.pop_front();
            n_vec++;
            if (cyc !== 11) begin
                n_err++;
                $display("FAIL latency8[%0d]: done at cycle %0d want 11", i, cyc);
            end
            n_vec++;
            if (busy1 !== 1'b1 || bus8.busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy8[%0d]: cycle1=%b done_cycle=%b want 1/1", i, busy1, bus8.busy);
            end
            n_vec++;
            if (bus8.result !== exp[7:0] || bus8.remainder !== exp[23:16]) begin
                n_err++;
                $display("FAIL quot_rem8[%0d] %h/%h: got q=%h r=%h want q=%h r=%h",
                         i, ta[i], tb[i], bus8.result, bus8.remainder, exp[7:0], exp[23:16]);
            end
            n_vec++;
            if (bus8.statusOut !== exp[35:32]) begin
                n_err++;
                $display("FAIL status8[%0d]: got %b want %b", i, bus8.statusOut, exp[35:32]);
            end
            @(negedge clk);
            n_vec++;
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
                n_err++;
                $display("FAIL pulse8[%0d]: after done got done=%b busy=%b want 0/0",
                         i, bus8.done, bus8.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp;
        logic busy1;
        int cyc, extra;
        run_op8(8'd100, 8'd7, 3, 10, cyc, busy1);
        exp = exp_q.pop_front();
        n_vec++;
        if (cyc !== 11 || bus8.result !== exp[7:0] || bus8.remainder !== exp[23:16]) begin
            n_err++;
            $display("FAIL ignored_start: cyc=%0d q=%h r=%h want cyc=11 q=%h r=%h",
                     cyc, bus8.result, bus8.remainder, exp[7:0], exp[23:16]);
        end
        extra = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL no_second_op: got %0d busy/done cycles want 0", extra);
        end
        n_vec++;
        if (bus8.result !== exp[7:0] || bus8.statusOut !== exp[35:32]) begin
            n_err++;
            $display("FAIL hold_in_idle: got q=%h st=%b want q=%h st=%b",
                     bus8.result, bus8.statusOut, exp[7:0], exp[35:32]);
        end
        run_op8(8'hF6, 8'd3, -1, -1, cyc, busy1);
        exp = exp_q.pop_front();
        n_vec++;
        if (cyc !== 11 || bus8.result !== exp[7:0] || bus8.remainder !== exp[23:16]) begin
            n_err++;
            $display("FAIL next_start: cyc=%0d q=%h r=%h want cyc=11 q=%h r=%h",
                     cyc, bus8.result, bus8.remainder, exp[7:0], exp[23:16]);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [35:0] exp;
        logic busy1;
        int cyc, pulses;
        @(negedge clk);
        bus8.start = 1'b1; bus8.operand1 = 8'd100; bus8.operand2 = 8'd7;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus8.busy, bus8.done, bus8.result, bus8.remainder, bus8.statusOut} !== 22'd0) begin
            n_err++;
            $display("FAIL midop_reset: got busy=%b done=%b res=%h rem=%h st=%b want all zero",
                     bus8.busy, bus8.done, bus8.result, bus8.remainder, bus8.statusOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL aborted_done: got %0d done pulses want 0", pulses);
        end
        run_op8(8'd0, 8'd9, -1, -1, cyc, busy1);
        exp = exp_q.pop_front();
        n_vec++;
        if (cyc !== 11 || bus8.result !== 8'h00 || bus8.statusOut !== 4'b0100
            || bus8.result !== exp[7:0]) begin
            n_err++;
            $display("FAIL after_reset_op: cyc=%0d q=%h st=%b want cyc=11 q=00 st=0100",
                     cyc, bus8.result, bus8.statusOut);
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b;
        logic [35:0] exp;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            case (i)
                0: begin a = 16'h8000; b = 16'hFFFF; end
                1: b = 16'h0000;
                2: begin a = 16'h8000; b = 16'h0001; end
                3: begin a = 16'hFFFF; b = 16'h8000; end
                4: begin a = 16'h7FFF; b = 16'h8000; end
                default: if (i % 3 == 0) b = 16'($urandom_range(1, 15));
                         else if (i % 3 == 1) b = -16'($urandom_range(1, 300));
            endcase
            run_op16(a, b, cyc);
            exp = exp_q.pop_front();
            n_vec++;
            if (cyc !== 19) begin
                n_err++;
                $display("FAIL latency16[%0d]: done at cycle %0d want 19", i, cyc);
            end
            n_vec++;
            if (bus16.result !== exp[15:0] || bus16.remainder !== exp[31:16]
                || bus16.statusOut !== exp[35:32]) begin
                n_err++;
                $display("FAIL random16[%0d] %h/%h: got q=%h r=%h st=%b want q=%h r=%h st=%b",
                         i, a, b, bus16.result, bus16.remainder, bus16.statusOut,
                         exp[15:0], exp[31:16], exp[35:32]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus8.start = 1'b0;  bus8.operand1 = '0;  bus8.operand2 = '0;
        bus16.start = 1'b0; bus16.operand1 = '0; bus16.operand2 = '0;
        test_reset();
        test_directed8();
        test_back_to_back();
        test_reset_mid_op();
        test_random16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
